// File: rtl/control_seq.sv
// control_seq: fetch/execute sequencer that decodes a move-style instruction word into
// bus source enables, destination load strobes and conditional jumps.
module control_seq #(
    parameter int SRC_BITS = 2,
    parameter int DEST_BITS = 3,
    parameter int FLAG_LATCH = 1,
    localparam int IRW = 3 + SRC_BITS + DEST_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ready,
    input  logic [IRW-1:0]            bus_in,
    input  logic                      alu_zero,
    input  logic                      alu_carry,
    output logic [IRW-1:0]            ir,
    output logic                      fetch,
    output logic [2**SRC_BITS-1:0]    src_en,
    output logic [2**DEST_BITS-1:0]   load_en,
    output logic                      immediate,
    output logic                      do_subtract,
    output logic                      do_jump,
    output logic                      pc_inc,
    output logic                      halted,
    output logic                      flag_z,
    output logic                      flag_c
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    localparam logic [DEST_BITS-1:0] PC_D = DEST_BITS'(1);
    localparam logic [DEST_BITS-1:0] A_D = DEST_BITS'(2);
    localparam logic [DEST_BITS-1:0] HALT_D = '1;
    localparam logic [SRC_BITS-1:0] E_S = SRC_BITS'(1);
    state_t state, state_next;
    logic [SRC_BITS-1:0] source;
    logic [DEST_BITS-1:0] dest;
    logic c_cond, z_cond, indexed, zf, cf, cond;
    assign c_cond = ir[IRW-1];
    assign z_cond = ir[IRW-2];
    assign source = ir[IRW-3 -: SRC_BITS];
    assign dest = ir[DEST_BITS:1];
    assign indexed = ir[0];
    assign zf = (FLAG_LATCH != 0) ? flag_z : alu_zero;
    assign cf = (FLAG_LATCH != 0) ? flag_c : alu_carry;
    // both condition bits set means an unconditional jump
    assign cond = (z_cond & zf) | (c_cond & cf) | (z_cond & c_cond);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ir <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FETCH && ready)
                ir <= bus_in;
            if (state == EXEC && ready && dest == A_D && source == E_S) begin
                flag_z <= alu_zero;
                flag_c <= alu_carry;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (ready && state == FETCH)
            state_next = EXEC;
        if (ready && state == EXEC)
            state_next = (dest == HALT_D) ? HALT : FETCH;
    end

    always_comb begin
        fetch = 1'b0;
        src_en = '0;
        load_en = '0;
        immediate = 1'b0;
        do_subtract = 1'b0;
        do_jump = 1'b0;
        pc_inc = 1'b0;
        halted = 1'b0;
        case (state)
            FETCH: begin
                fetch = 1'b1;
                pc_inc = ready;
            end
            EXEC: begin
                src_en[source] = 1'b1;
                immediate = ~indexed;
                do_subtract = z_cond;
                if (dest == PC_D) begin
                    do_jump = ready & cond;
                    load_en[PC_D] = ready & cond;
                    pc_inc = ready & ~cond & ~indexed;
                end else if (dest != HALT_D) begin
                    load_en[dest] = ready;
                    pc_inc = ready & ~indexed;
                end
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: randomized scoreboard bench for default, live-flag and widened control_seq variants
module tb_control_seq;
  typedef struct packed {
    logic [9:0]  ir;
    logic        fetch;
    logic [7:0]  src_en;
    logic [15:0] load_en;
    logic        imm, sub, jmp, pci, hlt, fz, fc;
  } obs_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, ready, alu_zero, alu_carry;
  logic [7:0] bus_n [2];
  logic [9:0] bus_w;
  wire [7:0] ir_n [2];
  wire [3:0] se_n [2];
  wire [7:0] le_n [2];
  wire [9:0] ir_w;
  wire [7:0] se_w;
  wire [15:0] le_w;
  wire [2:0] fe, im, su, jp, pi, ha, fz, fc;
  control_seq u0 (.clk(clk), .reset(reset), .ready(ready), .bus_in(bus_n[0]), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .ir(ir_n[0]), .fetch(fe[0]), .src_en(se_n[0]), .load_en(le_n[0]),
    .immediate(im[0]), .do_subtract(su[0]), .do_jump(jp[0]), .pc_inc(pi[0]), .halted(ha[0]),
    .flag_z(fz[0]), .flag_c(fc[0]));
  control_seq #(.FLAG_LATCH(0)) u1 (.clk(clk), .reset(reset), .ready(ready), .bus_in(bus_n[1]),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .ir(ir_n[1]), .fetch(fe[1]), .src_en(se_n[1]),
    .load_en(le_n[1]), .immediate(im[1]), .do_subtract(su[1]), .do_jump(jp[1]), .pc_inc(pi[1]),
    .halted(ha[1]), .flag_z(fz[1]), .flag_c(fc[1]));
  control_seq #(.SRC_BITS(3), .DEST_BITS(4)) u2 (.clk(clk), .reset(reset), .ready(ready),
    .bus_in(bus_w), .alu_zero(alu_zero), .alu_carry(alu_carry), .ir(ir_w), .fetch(fe[2]),
    .src_en(se_w), .load_en(le_w), .immediate(im[2]), .do_subtract(su[2]), .do_jump(jp[2]),
    .pc_inc(pi[2]), .halted(ha[2]), .flag_z(fz[2]), .flag_c(fc[2]));
  int sbp [3] = '{2, 2, 3};
  int dbp [3] = '{3, 3, 4};
  int flp [3] = '{1, 0, 1};
  logic [9:0] prog [3][4] = '{'{10'h014, 10'h042, 10'h082, 10'h00E},
                             '{10'h014, 10'h042, 10'h082, 10'h00E},
                             '{10'h024, 10'h102, 10'h202, 10'h01E}};
  int ph [3];
  int fn [3];
  logic [9:0] mir [3];
  logic mfz [3], mfc [3];
  obs_t exp_q [$];
  int k_q [$];
  int checks = 0, errors = 0, pushed = 0;
  function automatic int fld_src(int k);
    return int'(mir[k] >> (dbp[k] + 1)) & ((1 << sbp[k]) - 1);
  endfunction
  function automatic int fld_dst(int k);
    return int'(mir[k] >> 1) & ((1 << dbp[k]) - 1);
  endfunction
  function automatic obs_t expect_of(int k, logic rdy, logic az, logic ac);
    obs_t o = '0;
    int irw = 3 + sbp[k] + dbp[k];
    int dst = fld_dst(k);
    logic c = mir[k][irw-1];
    logic z = mir[k][irw-2];
    logic idx = mir[k][0];
    logic zz = (flp[k] != 0) ? mfz[k] : az;
    logic cc = (flp[k] != 0) ? mfc[k] : ac;
    logic cond = (z & zz) | (c & cc) | (z & c);
    o.ir = mir[k];
    o.fz = mfz[k];
    o.fc = mfc[k];
    if (ph[k] == 0) begin
      o.fetch = 1'b1;
      o.pci = rdy;
    end else if (ph[k] == 2) begin
      o.hlt = 1'b1;
    end else begin
      o.src_en = 8'(1 << fld_src(k));
      o.imm = ~idx;
      o.sub = z;
      if (dst == 1) begin
        if (rdy && cond) begin
          o.jmp = 1'b1;
          o.load_en = 16'd2;
        end else o.pci = rdy & ~idx;
      end else if (dst != (1 << dbp[k]) - 1) begin
        o.load_en = 16'(1 << dst) & {16{rdy}};
        o.pci = rdy & ~idx;
      end
    end
    return o;
  endfunction
  task automatic step_model(int k, logic rst, logic rdy, logic az, logic ac, logic [9:0] b);
    if (rst) begin
      ph[k] = 0;
      mir[k] = '0;
      mfz[k] = 1'b0;
      mfc[k] = 1'b0;
    end else if (ph[k] == 0 && rdy) begin
      mir[k] = b;
      ph[k] = 1;
      fn[k]++;
    end else if (ph[k] == 1 && rdy) begin
      if (fld_dst(k) == 2 && fld_src(k) == 1) begin
        mfz[k] = az;
        mfc[k] = ac;
      end
      ph[k] = (fld_dst(k) == (1 << dbp[k]) - 1) ? 2 : 0;
    end
  endtask
  function automatic logic [9:0] mk(int k);
    int db = dbp[k];
    int irw = 3 + sbp[k] + db;
    int r = $urandom_range(0, 3);
    int v = int'($urandom) & ((1 << irw) - 1);
    if (r == 0)
      v = (v & ~(((1 << sbp[k]) - 1) << (db + 1)) & ~(((1 << db) - 1) << 1)) | (1 << (db + 1)) | 4;
    if (r == 1)
      v = (v & ~(((1 << db) - 1) << 1)) | 2;
    return 10'(v);
  endfunction
  initial begin
    logic [9:0] word [3];
    int w;
    reset = 1'b1;
    ready = 1'b0;
    alu_zero = 1'b0;
    alu_carry = 1'b0;
    bus_n[0] = '0;
    bus_n[1] = '0;
    bus_w = '0;
    for (int k = 0; k < 3; k++) fn[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ir_n[0] !== 8'd0 || ir_n[1] !== 8'd0 || ir_w !== 10'd0 || fz !== 3'b000 || fc !== 3'b000
        || fe !== 3'b111 || ha !== 3'b000) begin
      errors++;
      $display("FAIL reset state at %0t: ir=%h/%h/%h fz=%b fc=%b fetch=%b halted=%b",
        $time, ir_n[0], ir_n[1], ir_w, fz, fc, fe, ha);
    end
    for (int k = 0; k < 3; k++) step_model(k, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int cyc = 0; cyc < 700; cyc++) begin
      reset = (cyc > 30) && ($urandom_range(0, 99) < 4);
      ready = (cyc < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
      alu_zero = (cyc < 12) ? 1'b1 : 1'($urandom_range(0, 1));
      alu_carry = (cyc < 12) ? (cyc == 5) : 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) word[k] = (fn[k] < 4) ? prog[k][fn[k]] : mk(k);
      bus_n[0] = word[0][7:0];
      bus_n[1] = word[1][7:0];
      bus_w = word[2];
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back(expect_of(k, ready, alu_zero, alu_carry));
        k_q.push_back(k);
        pushed++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) step_model(k, reset, ready, alu_zero, alu_carry, word[k]);
    end
    w = 0;
    while (exp_q.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || checks != pushed + 2) begin
      errors++;
      $display("FAIL wait expired at %0t: pending=%0d compared=%0d queued=%0d",
        $time, exp_q.size(), checks - 2, pushed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      obs_t e, a;
      int k;
      e = exp_q.pop_front();
      k = k_q.pop_front();
      a = '0;
      if (k == 2) begin
        a.ir = ir_w;
        a.src_en = se_w;
        a.load_en = le_w;
      end else begin
        a.ir = {2'b0, ir_n[k[0]]};
        a.src_en = {4'b0, se_n[k[0]]};
        a.load_en = {8'b0, le_n[k[0]]};
      end
      a.fetch = fe[k];
      a.imm = im[k];
      a.sub = su[k];
      a.jmp = jp[k];
      a.pci = pi[k];
      a.hlt = ha[k];
      a.fz = fz[k];
      a.fc = fc[k];
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut%0d outputs at %0t: got=%h expected=%h", k, $time, a, e);
      end
    end
  end
endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter SRC_BITS, default 2, width of the source field; the block has 2**SRC_BITS bus sources.
REQ-002 Parameter DEST_BITS, default 3, width of the destination field; the block has 2**DEST_BITS destinations.
REQ-003 Parameter FLAG_LATCH, default 1: 1 = jumps test the registered flags, 0 = jumps test the live ALU flags.
REQ-004 Derived IRW = 3+SRC_BITS+DEST_BITS. IR layout, MSB first: bit7/carry-cond (1), bit6/zero-cond (1), source, dest, indexed (1).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 ready  in  1  memory/bus ready; 0 stalls the sequencer.
REQ-008 bus_in  in  IRW  instruction word from memory, captured in FETCH.
REQ-009 alu_zero, alu_carry  in  1 each  live ALU result flags.
REQ-010 ir  out  IRW  instruction register.
REQ-011 fetch  out  1  high in FETCH state (memory addressed by PC, IR loading).
REQ-012 src_en  out  2**SRC_BITS  one-hot bus-source enable, active-high.
REQ-013 load_en  out  2**DEST_BITS  one-hot destination load strobe, active-high, one cycle.
REQ-014 immediate, do_subtract, do_jump, pc_inc, halted  out  1 each.
REQ-015 flag_z, flag_c  out  1 each  registered flags.

Function
REQ-016 States: FETCH, EXEC, HALT; 2-bit encoded state register.
REQ-017 FETCH: fetch=1, pc_inc=1, src_en=0, load_en=0; on the edge with ready=1, ir<=bus_in and state<=EXEC.
REQ-018 EXEC: fetch=0; src_en is one-hot at index ir.source; immediate=~ir.indexed; do_subtract=ir.bit6.
REQ-019 EXEC with dest != PC (index 1) and dest != HALT (index 2**DEST_BITS-1): load_en[dest]=1, do_jump=0, pc_inc=immediate.
REQ-020 EXEC with dest == PC: cond = (bit6 & Z) | (bit7 & C) | (bit6 & bit7), where Z/C are flag_z/flag_c if FLAG_LATCH=1, else alu_zero/alu_carry.
REQ-021 When cond=1: do_jump=1, load_en[1]=1, pc_inc=0.
REQ-022 When cond=0: do_jump=0, load_en=0, pc_inc=immediate (operand skipped).
REQ-023 EXEC with dest == HALT: load_en=0, pc_inc=0; on the edge with ready=1, state<=HALT.
REQ-024 All other EXEC instructions: on the edge with ready=1, state<=FETCH.
REQ-025 ready=0 in FETCH or EXEC: state, ir and flags hold; load_en=0, do_jump=0, pc_inc=0; src_en and fetch remain asserted.
REQ-026 Flag update: on an EXEC edge with ready=1, dest == A (index 2) and source == E (index 1), flag_z<=alu_zero and flag_c<=alu_carry; otherwise the flags hold.
REQ-027 A jump uses flag values from before its own EXEC edge; a flag update and a jump never coincide because they target different dests.
REQ-028 HALT: halted=1; every other output is 0 except ir and the flags, which hold; the block leaves HALT only via reset; ready is ignored.
REQ-029 Index 0 (IR) as dest in EXEC is a legal no-op reload: load_en[0]=1.
REQ-030 All outputs except ir, flag_z and flag_c are combinational from state, ir, ready and flags, with no decoded output asserted outside EXEC.

Reset
REQ-031 reset=1 at an edge: state<=FETCH, ir<=0, flag_z<=0, flag_c<=0; reset takes priority over ready and over all state transitions, including mid-EXEC and in HALT.
REQ-032 While reset is held, the block stays in FETCH and captures nothing; the first fetch occurs on the first edge after reset is deasserted.

Verification
REQ-033 Reset, then ready=1 and bus_in=8'b00_01_010_0 -> FETCH 1 cycle; EXEC: src_en=0010, load_en=00000100, immediate=1, pc_inc=1; next cycle FETCH.
REQ-034 ALU to A with alu_zero=1, alu_carry=0 -> flag_z=1, flag_c=0; then ir=8'b01_00_001_0 -> do_jump=1, load_en[1]=1, pc_inc=0.
REQ-035 flag_z=0, flag_c=0, ir=8'b10_00_001_0 -> do_jump=0, load_en=0, pc_inc=1; with FLAG_LATCH=0 and alu_carry=1 on the same opcode -> do_jump=1.
REQ-036 ready=0 held for 3 cycles in EXEC of an A-load -> load_en=0 throughout, state is still EXEC; ready=1 -> a single load_en[2] pulse.
REQ-037 ir dest=111 -> HALT; halted=1 held for 10 cycles with ready toggling; reset -> FETCH, ir=0, flags=0.
REQ-038 SRC_BITS=3, DEST_BITS=4 (IRW=10) -> one-hot widths 8/16, HALT at dest 15, and REQ-033 is repeated with the widened fields.
